// File: rtl/conv_pkg.sv
// Shared types and helpers for the feature-map pool scanner: FSM state enum and
// lane pack/unpack of the packed OUT_CHANNELS x BITS_PER_NEURON BRAM word.
package conv_pkg;

    localparam int FMAP_MAX_W = 1024;
    localparam int FMAP_IW    = $clog2(FMAP_MAX_W);

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_FILL,
        PS_STREAM,
        PS_EMIT,
        PS_NEXT,
        PS_DONE
    } pool_scan_state_t;

    // Channel ch of a word holding bpn-bit lanes, sign-extended to 32 bits.
    function automatic logic signed [31:0] unpack_fmap(input logic [FMAP_MAX_W-1:0] word,
                                                       input int ch, input int bpn);
        logic signed [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            r[5'(i)] = (i < bpn) ? word[FMAP_IW'(ch*bpn + i)] : word[FMAP_IW'(ch*bpn + bpn - 1)];
        return r;
    endfunction

    function automatic logic [FMAP_MAX_W-1:0] pack_fmap(input logic [FMAP_MAX_W-1:0] word,
                                                        input int ch, input int bpn,
                                                        input logic signed [31:0] val);
        logic [FMAP_MAX_W-1:0] r;
        r = word;
        for (int i = 0; i < 32; i++)
            if (i < bpn) r[FMAP_IW'(ch*bpn + i)] = val[5'(i)];
        return r;
    endfunction

endpackage

// File: rtl/pool_window_accum.sv
// Per-channel signed window accumulators with clear and threshold compare.
// spike_next_o looks at the sum including the pixel being consumed this cycle.
module pool_window_accum
    import conv_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int BPN       = 8,
    parameter int AW        = 10,
    parameter int THRESHOLD = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [LANES*BPN-1:0] din_i,
    output logic [LANES-1:0]     spike_o,
    output logic [LANES-1:0]     spike_next_o
);

    logic [FMAP_MAX_W-1:0] din_ext;
    assign din_ext = FMAP_MAX_W'(din_i);

    for (genvar c = 0; c < LANES; c++) begin : g_lane
        logic signed [AW-1:0] acc_q, acc_d;

        always_comb acc_d = acc_q + AW'(unpack_fmap(din_ext, c, BPN));

        always_ff @(posedge clk) begin
            if (rst || clr_i) acc_q <= '0;
            else if (en_i)    acc_q <= acc_d;
        end

        assign spike_o[c]      = int'(acc_q) >= THRESHOLD;
        assign spike_next_o[c] = int'(acc_d) >= THRESHOLD;
    end

endmodule

// File: rtl/fmap_pool_scanner.sv
// Pool-phase scanner: streams each POOL_SIZE^2 window through the accumulators,
// writes back every pixel and emits one spike event per window over threshold.
// Define FMAP_POOL_DECAY_EN for a leaky write-back instead of a hard reset to 0.
module fmap_pool_scanner
    import conv_pkg::*;
#(
    parameter int BITS_PER_COORDINATE = 8,
    parameter int OUT_CHANNELS        = 4,
    parameter int BITS_PER_NEURON     = 8,
    parameter int IMG_WIDTH           = 32,
    parameter int IMG_HEIGHT          = 32,
    parameter int POOL_SIZE           = 2,
    parameter int THRESHOLD           = 64,
    parameter int DECAY_SHIFT         = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      rd_req,
    output logic [BITS_PER_COORDINATE-1:0]            rd_x,
    output logic [BITS_PER_COORDINATE-1:0]            rd_y,
    input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]   rd_data,
    output logic                                      wr_req,
    output logic [BITS_PER_COORDINATE-1:0]            wr_x,
    output logic [BITS_PER_COORDINATE-1:0]            wr_y,
    output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]   wr_data,
    output logic                                      evt_valid,
    input  logic                                      evt_ready,
    output logic [BITS_PER_COORDINATE-1:0]            evt_x,
    output logic [BITS_PER_COORDINATE-1:0]            evt_y,
    output logic [OUT_CHANNELS-1:0]                   evt_spikes
);

    localparam int BPC     = BITS_PER_COORDINATE;
    localparam int W       = OUT_CHANNELS * BITS_PER_NEURON;
    localparam int NPIX    = POOL_SIZE * POOL_SIZE;
    localparam int KW      = $clog2(NPIX + 1);
    localparam int AW      = BITS_PER_NEURON + 2 * $clog2(POOL_SIZE);
    localparam int WX_LAST = IMG_WIDTH / POOL_SIZE - 1;
    localparam int WY_LAST = IMG_HEIGHT / POOL_SIZE - 1;

    if (IMG_WIDTH % POOL_SIZE != 0)  begin : g_chk_w $error("IMG_WIDTH not divisible by POOL_SIZE");  end
    if (IMG_HEIGHT % POOL_SIZE != 0) begin : g_chk_h $error("IMG_HEIGHT not divisible by POOL_SIZE"); end
    if (W > FMAP_MAX_W)              begin : g_chk_d $error("packed word wider than FMAP_MAX_W");     end
    if (DECAY_SHIFT < 0 || DECAY_SHIFT >= BITS_PER_NEURON) begin : g_chk_s $error("bad DECAY_SHIFT"); end

    pool_scan_state_t       state_q, state_d;
    logic [KW-1:0]          k_q, k_d, rd_k;
    logic [BPC-1:0]         wx_q, wx_d, wy_q, wy_d;
    logic                   acc_clr, acc_en;
    logic [OUT_CHANNELS-1:0] spike, spike_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_IDLE;
            k_q     <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wx_d      = wx_q;
        wy_d      = wy_q;
        rd_k      = '0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        evt_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            PS_IDLE: if (start) state_d = PS_FILL;
            PS_FILL: begin
                rd_req  = 1'b1;
                acc_clr = 1'b1;
                k_d     = '0;
                state_d = PS_STREAM;
            end
            // Write pixel k while reading k+1: addresses never collide.
            PS_STREAM: begin
                acc_en = 1'b1;
                wr_req = 1'b1;
                if (k_q != KW'(NPIX - 1)) begin
                    rd_req = 1'b1;
                    rd_k   = k_q + KW'(1);
                    k_d    = k_q + KW'(1);
                end else begin
                    state_d = (|spike_next) ? PS_EMIT : PS_NEXT;
                end
            end
            PS_EMIT: begin
                evt_valid = 1'b1;
                if (evt_ready) state_d = PS_NEXT;
            end
            PS_NEXT: begin
                state_d = PS_FILL;
                if (wx_q == BPC'(WX_LAST)) begin
                    wx_d = '0;
                    if (wy_q == BPC'(WY_LAST)) state_d = PS_DONE;
                    else                       wy_d    = wy_q + BPC'(1);
                end else begin
                    wx_d = wx_q + BPC'(1);
                end
            end
            PS_DONE: begin
                done    = 1'b1;
                wx_d    = '0;
                wy_d    = '0;
                state_d = PS_IDLE;
            end
            default: state_d = PS_IDLE;
        endcase
    end

    assign busy = (state_q != PS_IDLE);

    assign rd_x = rd_req ? BPC'(int'(wx_q) * POOL_SIZE + int'(rd_k) % POOL_SIZE) : '0;
    assign rd_y = rd_req ? BPC'(int'(wy_q) * POOL_SIZE + int'(rd_k) / POOL_SIZE) : '0;
    assign wr_x = wr_req ? BPC'(int'(wx_q) * POOL_SIZE + int'(k_q) % POOL_SIZE) : '0;
    assign wr_y = wr_req ? BPC'(int'(wy_q) * POOL_SIZE + int'(k_q) / POOL_SIZE) : '0;

    assign evt_x      = evt_valid ? wx_q  : '0;
    assign evt_y      = evt_valid ? wy_q  : '0;
    assign evt_spikes = evt_valid ? spike : '0;

    pool_window_accum #(
        .LANES     (OUT_CHANNELS),
        .BPN       (BITS_PER_NEURON),
        .AW        (AW),
        .THRESHOLD (THRESHOLD)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (acc_clr),
        .en_i         (acc_en),
        .din_i        (rd_data),
        .spike_o      (spike),
        .spike_next_o (spike_next)
    );

`ifdef FMAP_POOL_DECAY_EN
    logic [FMAP_MAX_W-1:0] rd_ext, wb_word;
    assign rd_ext = FMAP_MAX_W'(rd_data);

    // Signed leak: v - (v >>> DECAY_SHIFT) per channel.
    always_comb begin
        wb_word = '0;
        for (int c = 0; c < OUT_CHANNELS; c++)
            wb_word = pack_fmap(wb_word, c, BITS_PER_NEURON,
                                unpack_fmap(rd_ext, c, BITS_PER_NEURON) -
                                (unpack_fmap(rd_ext, c, BITS_PER_NEURON) >>> DECAY_SHIFT));
    end
    assign wr_data = wr_req ? W'(wb_word) : '0;
`else
    assign wr_data = '0;
`endif

endmodule
